// File: rtl/p2a_cpl_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : p2a_cpl_buffer
//  Purpose  : Completion buffer of the P2A mapper. It takes multi-beat
//             completions from the Rx Router and stores each header in a
//             header FIFO and its data beats in a separate data FIFO. It then
//             replays every completion to the Push FSM as one header phase
//             followed by its data beats.
//  Ports    : clk, rst                 - clock, synchronous active-high reset
//             resp_*_i / resp_grant_o  - Rx Router beat interface
//             cpl_*_o / cpl_grant_i,
//             cpl_command_i            - Push FSM interface (0=hdr, 1=data)
//             hdr_count_o/data_count_o - FIFO occupancies
//             len_err_o, cmd_err_o     - sticky protocol error flags
//  Revision : 1.0 - initial release
// ============================================================================
module p2a_cpl_buffer #(
    parameter int DATA_WIDTH = 1024,
    parameter int HDR_DEPTH  = 8,
    parameter int DATA_DEPTH = 32,
    parameter int TAG_WIDTH  = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          resp_valid_i,
    output logic                          resp_grant_o,
    input  logic [1:0]                    resp_type_i,
    input  logic [9:0]                    resp_length_i,
    input  logic [TAG_WIDTH-1:0]          resp_tag_i,
    input  logic [DATA_WIDTH-1:0]         resp_data_i,
    input  logic                          resp_last_i,
    output logic                          cpl_valid_o,
    input  logic                          cpl_grant_i,
    input  logic                          cpl_command_i,
    output logic [1:0]                    cpl_type_o,
    output logic [9:0]                    cpl_length_o,
    output logic [TAG_WIDTH-1:0]          cpl_tag_o,
    output logic [DATA_WIDTH-1:0]         cpl_data_o,
    output logic                          cpl_last_o,
    output logic [$clog2(HDR_DEPTH):0]    hdr_count_o,
    output logic [$clog2(DATA_DEPTH):0]   data_count_o,
    output logic                          len_err_o,
    output logic                          cmd_err_o
);

    localparam int         HAW         = $clog2(HDR_DEPTH);
    localparam int         DAW         = $clog2(DATA_DEPTH);
    localparam int         HW          = 2 + 10 + TAG_WIDTH;
    localparam int         DW_PER_BEAT = DATA_WIDTH / 32;
    localparam logic [1:0] TYPE_CPLD   = 2'd1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    // Beats needed to carry a completion of the given DW length
    // (length 0 encodes 1024 DW).
    function automatic logic [10:0] beats_of(input logic [9:0] len);
        logic [10:0] dw;
        dw = (len == 10'd0) ? 11'd1024 : {1'b0, len};
        return 11'((32'(dw) + DW_PER_BEAT - 1) / DW_PER_BEAT);
    endfunction

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [HW-1:0]         hdr_mem_q  [HDR_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [DATA_DEPTH];

    logic [HAW-1:0] hdr_wr_q,  hdr_wr_d,  hdr_rd_q,  hdr_rd_d;
    logic [HAW:0]   hdr_cnt_q, hdr_cnt_d;
    logic [DAW-1:0] dat_wr_q,  dat_wr_d,  dat_rd_q,  dat_rd_d;
    logic [DAW:0]   dat_cnt_q, dat_cnt_d;

    // Input-side completion tracking
    logic           in_sop_q,   in_sop_d;
    logic [1:0]     cur_type_q, cur_type_d;
    logic [9:0]     cur_len_q,  cur_len_d;
    logic [10:0]    beat_cnt_q, beat_cnt_d;
    logic           len_err_q,  len_err_d;

    // Output-side FSM
    state_t         state_q,    state_d;
    logic [10:0]    beats_rem_q, beats_rem_d;
    logic           cmd_err_q,  cmd_err_d;

    logic           w_hdr_full, w_dat_full, w_dat_avail;
    logic           w_accept, w_hdr_push, w_dat_push, w_hdr_pop, w_dat_pop;
    logic [1:0]     w_type;
    logic [9:0]     w_len;
    logic [10:0]    w_cnt;
    logic [HW-1:0]  w_hdr_head;
    logic [1:0]     w_head_type;
    logic [9:0]     w_head_len;
    logic [TAG_WIDTH-1:0] w_head_tag;

    assign w_hdr_full  = (hdr_cnt_q == (HAW+1)'(HDR_DEPTH));
    assign w_dat_full  = (dat_cnt_q == (DAW+1)'(DATA_DEPTH));
    assign w_dat_avail = (dat_cnt_q != '0);

    assign w_hdr_head  = hdr_mem_q[hdr_rd_q];
    assign w_head_type = w_hdr_head[HW-1 -: 2];
    assign w_head_len  = w_hdr_head[TAG_WIDTH +: 10];
    assign w_head_tag  = w_hdr_head[TAG_WIDTH-1:0];

    // ------------------------------------------------------------------
    // Input side
    // ------------------------------------------------------------------
    assign resp_grant_o = !w_dat_full && (!in_sop_q || !w_hdr_full);
    assign w_accept     = resp_valid_i && resp_grant_o;

    // Header fields are only valid on the SOP beat, so later beats use the
    // values latched at SOP.
    assign w_type     = in_sop_q ? resp_type_i   : cur_type_q;
    assign w_len      = in_sop_q ? resp_length_i : cur_len_q;
    assign w_cnt      = (in_sop_q ? 11'd0 : beat_cnt_q) + 11'd1;
    assign w_hdr_push = w_accept && in_sop_q;
    assign w_dat_push = w_accept && (w_type == TYPE_CPLD);

    always_comb begin
        in_sop_d   = in_sop_q;
        cur_type_d = cur_type_q;
        cur_len_d  = cur_len_q;
        beat_cnt_d = beat_cnt_q;
        len_err_d  = len_err_q;
        if (w_accept) begin
            cur_type_d = w_type;
            cur_len_d  = w_len;
            if (resp_last_i) begin
                in_sop_d   = 1'b1;
                beat_cnt_d = 11'd0;
                if (w_type == TYPE_CPLD) begin
                    if (w_cnt != beats_of(w_len)) len_err_d = 1'b1;
                end else begin
                    if (w_cnt != 11'd1) len_err_d = 1'b1;
                end
            end else begin
                in_sop_d   = 1'b0;
                beat_cnt_d = w_cnt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        beats_rem_d = beats_rem_q;
        cmd_err_d   = cmd_err_q;
        w_hdr_pop   = 1'b0;
        w_dat_pop   = 1'b0;
        cpl_valid_o = 1'b0;
        cpl_last_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hdr_cnt_q != '0) state_d = S_HDR;
            end
            S_HDR: begin
                cpl_valid_o = 1'b1;
                if (cpl_grant_i) begin
                    if (cpl_command_i) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        w_hdr_pop = 1'b1;
                        if (w_head_type == TYPE_CPLD) begin
                            beats_rem_d = beats_of(w_head_len);
                            state_d     = S_DATA;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_DATA: begin
                // The header may have been replayed before all of its data
                // arrived, so the data phase stalls on an empty data FIFO.
                cpl_valid_o = w_dat_avail;
                cpl_last_o  = w_dat_avail && (beats_rem_q == 11'd1);
                if (cpl_grant_i) begin
                    if (!cpl_command_i) begin
                        cmd_err_d = 1'b1;
                    end else if (w_dat_avail) begin
                        w_dat_pop   = 1'b1;
                        beats_rem_d = beats_rem_q - 11'd1;
                        if (beats_rem_q == 11'd1) state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cpl_type_o   = (state_q == S_HDR) ? w_head_type : 2'd0;
    assign cpl_length_o = (state_q == S_HDR) ? w_head_len  : 10'd0;
    assign cpl_tag_o    = (state_q == S_HDR) ? w_head_tag  : '0;
    assign cpl_data_o   = ((state_q == S_DATA) && w_dat_avail) ? data_mem_q[dat_rd_q] : '0;
    assign hdr_count_o  = hdr_cnt_q;
    assign data_count_o = dat_cnt_q;
    assign len_err_o    = len_err_q;
    assign cmd_err_o    = cmd_err_q;

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy (depths are powers of two, so the
    // pointers wrap naturally)
    // ------------------------------------------------------------------
    always_comb begin
        hdr_wr_d  = w_hdr_push ? hdr_wr_q + 1'b1 : hdr_wr_q;
        hdr_rd_d  = w_hdr_pop  ? hdr_rd_q + 1'b1 : hdr_rd_q;
        hdr_cnt_d = hdr_cnt_q;
        if (w_hdr_push && !w_hdr_pop)      hdr_cnt_d = hdr_cnt_q + 1'b1;
        else if (!w_hdr_push && w_hdr_pop) hdr_cnt_d = hdr_cnt_q - 1'b1;

        dat_wr_d  = w_dat_push ? dat_wr_q + 1'b1 : dat_wr_q;
        dat_rd_d  = w_dat_pop  ? dat_rd_q + 1'b1 : dat_rd_q;
        dat_cnt_d = dat_cnt_q;
        if (w_dat_push && !w_dat_pop)      dat_cnt_d = dat_cnt_q + 1'b1;
        else if (!w_dat_push && w_dat_pop) dat_cnt_d = dat_cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_wr_q    <= '0;
            hdr_rd_q    <= '0;
            hdr_cnt_q   <= '0;
            dat_wr_q    <= '0;
            dat_rd_q    <= '0;
            dat_cnt_q   <= '0;
            in_sop_q    <= 1'b1;
            cur_type_q  <= 2'd0;
            cur_len_q   <= 10'd0;
            beat_cnt_q  <= 11'd0;
            len_err_q   <= 1'b0;
            state_q     <= S_IDLE;
            beats_rem_q <= 11'd0;
            cmd_err_q   <= 1'b0;
        end else begin
            hdr_wr_q    <= hdr_wr_d;
            hdr_rd_q    <= hdr_rd_d;
            hdr_cnt_q   <= hdr_cnt_d;
            dat_wr_q    <= dat_wr_d;
            dat_rd_q    <= dat_rd_d;
            dat_cnt_q   <= dat_cnt_d;
            in_sop_q    <= in_sop_d;
            cur_type_q  <= cur_type_d;
            cur_len_q   <= cur_len_d;
            beat_cnt_q  <= beat_cnt_d;
            len_err_q   <= len_err_d;
            state_q     <= state_d;
            beats_rem_q <= beats_rem_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    // Storage arrays carry no reset; occupancy counters gate every read.
    always_ff @(posedge clk) begin
        if (w_hdr_push) hdr_mem_q[hdr_wr_q]  <= {resp_type_i, resp_length_i, resp_tag_i};
        if (w_dat_push) data_mem_q[dat_wr_q] <= resp_data_i;
    end

endmodule
`default_nettype wire
